// File: rtl/reg_bank_wb.sv
// rtl/reg_bank_wb.sv - 32x32 register bank with write counter (optional REG_BYPASS_EN forwarding)
module reg_bank_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_IDX   = 29,
  parameter int SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [7:0]        write_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [0:DEPTH-1];
  logic              commit;

  assign commit = reg_write && (write_reg != '0);

  // Entry 0 is only ever loaded by reset, so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
      write_count <= 8'd0;
    end else if (commit) begin
      regs[write_reg] <= write_data;
      if (write_count != 8'hFF) begin
        write_count <= write_count + 8'd1;
      end
    end
  end

  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  assign stored1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
  assign stored2 = (read_reg2 == '0) ? '0 : regs[read_reg2];

`ifdef REG_BYPASS_EN
  // Write-through: a port reading the register being written sees the new word now.
  assign read_data1 = (commit && (write_reg == read_reg1)) ? write_data : stored1;
  assign read_data2 = (commit && (write_reg == read_reg2)) ? write_data : stored2;
`else
  assign read_data1 = stored1;
  assign read_data2 = stored2;
`endif

endmodule

// File: tb/tb_reg_bank_wb.sv
// tb/tb_reg_bank_wb.sv - scoreboard bench for reg_bank_wb
module tb_reg_bank_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [7:0]  write_count;

  reg_bank_wb dut (
    .clk         (clk),
    .reset       (reset),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q [$];
  logic [31:0] model [32];
  int          model_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
    check(tag, obs, e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[29]   = 32'd227;
    model_count = 0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      model[a] = d;
      if (model_count < 255) model_count++;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    @(negedge clk);
    reg_write  = 1'b0;
    model_write(a, d);
  endtask

  task automatic expect_read(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    read_reg1 = r1;
    read_reg2 = r2;
    sb_q.push_back(model[r1]);
    sb_q.push_back(model[r2]);
    sb_q.push_back(32'(model_count));
    #1;
    sb_pop({tag, "_rd1"}, read_data1);
    sb_pop({tag, "_rd2"}, read_data2);
    sb_pop({tag, "_cnt"}, {24'd0, write_count});
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    expect_read("in_reset", 5'd29, 5'd5);
    reset = 1'b0;
    @(negedge clk);
    expect_read("post_reset", 5'd29, 5'd5);

    do_write(5'd8, 32'hDEADBEEF);
    expect_read("wr8", 5'd8, 5'd8);

    do_write(5'd0, 32'h12345678);
    expect_read("wr0", 5'd0, 5'd0);

    // same-cycle read and write of reg 9
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hA5A5A5A5;
    read_reg1 = 5'd9; read_reg2 = 5'd0;
`ifdef REG_BYPASS_EN
    sb_q.push_back(32'hA5A5A5A5);
`else
    sb_q.push_back(model[9]);
`endif
    #1;
    sb_pop("same_pre", read_data1);
    @(posedge clk);
    #1;
    model_write(5'd9, 32'hA5A5A5A5);
    sb_q.push_back(model[9]);
    sb_pop("same_post", read_data1);
    @(negedge clk);
    reg_write = 1'b0;
    expect_read("same_after", 5'd9, 5'd9);

    for (int k = 0; k < 16; k++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      do_write(a, d);
      expect_read("rand", a, 5'($urandom_range(0, 31)));
    end

    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd3;
    for (int i = 0; i < 300; i++) begin
      write_data = 32'(i);
      @(negedge clk);
      model_write(5'd3, 32'(i));
    end
    reg_write = 1'b0;
    expect_read("sat", 5'd3, 5'd29);

    do_write(5'd10, 32'h55);
    expect_read("wr10", 5'd10, 5'd10);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    expect_read("async_rst", 5'd10, 5'd29);
    for (int i = 0; i < 32; i += 2) expect_read("rst_all", 5'(i), 5'(i + 1));

    // write coinciding with reset is dropped; first write after release commits
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd12; write_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    expect_read("rst_wr", 5'd12, 5'd12);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reg_write = 1'b0;
    model_write(5'd12, 32'hCAFEF00D);
    expect_read("first_wr", 5'd12, 5'd29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- 32 x 32-bit general-purpose register bank for the multicycle MIPS datapath.
- Sits at the consumer end of the write-back source-data selection path:
  - the selected source word arrives on the write port;
  - the bank stores it and presents it on two read ports to the A/B operand registers.
- Write port is edge-triggered; read ports are combinational.
- Bank-wide reset sets the architectural start state.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- SP_IDX, 29, index of the stack pointer register.
- SP_RESET, 227, reset value of the SP_IDX register.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable, sampled on rising clk.
- write_reg  input  ADDR_W  destination register index.
- write_data  input  DATA_W  word from the source-data selector.
- read_reg1  input  ADDR_W  read port 1 index.
- read_reg2  input  ADDR_W  read port 2 index.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.
- write_count  output  8  count of committed writes since reset; saturates at 255.

Behaviour:
- Reset:
  - Asynchronous, active-high; one clock and no other clock domains.
  - While reset is high, all registers are 0 except SP_IDX, which is SP_RESET.
  - write_count is 0 while reset is high.
  - Outputs reflect reset contents immediately, without waiting for a clk edge.
- Reset mid-operation:
  - Reset asserted in the same cycle as a write wins; the write is discarded.
  - The first write after reset deasserts commits on the next rising clk with reg_write=1.
- Write:
  - On rising clk with reg_write=1 and write_reg != 0, regs[write_reg] <= write_data.
  - Latency is 1 cycle: the value is visible on the read ports after that edge.
- Register 0:
  - Hardwired zero; writes to index 0 are dropped.
  - read_dataN is 0 whenever read_regN == 0.
- Write counter:
  - write_count increments by 1 on each committed write, i.e. reg_write=1 and write_reg != 0.
  - It holds at 255 once reached; there is no wrap-around.
  - Dropped writes to register 0 do not count.
- Reads:
  - Purely combinational: read_dataN = regs[read_regN].
  - Both ports may address the same register, and both return the same value.
- Read and write in the same cycle to the same index (bypass macro undefined):
  - Before the edge, the read returns the old value.
  - After the edge, it returns the new value.
- No X propagation: every index 0..31 is defined at all times after reset.
- No state machine beyond the storage array and the write counter; the register array is the only storage.

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined: a read port whose index equals write_reg while reg_write=1 and write_reg != 0 returns write_data combinationally in the same cycle (write-through forwarding).
  - Storage update timing is unchanged.
  - Port 1 and port 2 forward independently.
- Undefined: reads always return stored contents, as described in Behaviour.

Test Plan:
- Reset, then read_reg1=29 and read_reg2=5 -> read_data1=227, read_data2=0, write_count=0.
- Write 0xDEADBEEF to reg 8; after the edge set read_reg1=8 -> read_data1=0xDEADBEEF, write_count=1.
- Write 0x12345678 to reg 0, then read reg 0 on both ports -> both 0, write_count unchanged.
- Same-cycle read and write of reg 9 with 0xA5A5A5A5 (old value 0):
  - Without REG_BYPASS_EN -> read_data1=0 before the edge, 0xA5A5A5A5 after.
  - With REG_BYPASS_EN -> 0xA5A5A5A5 in the same cycle.
- 300 consecutive writes to reg 3 with incrementing data -> write_count=255 (saturated), reg 3 holds the last value (299).
- Write 0x55 to reg 10, then assert reset asynchronously between edges -> read_data of reg 10 goes to 0 immediately, reg 29 reads 227, write_count=0.
